// File: rtl/popcount_ctrl_pkg.sv
// Shared types and width helper for the chunked popcount sequencer and its bench.
package popcount_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } popcnt_state_t;

    // Bits needed to hold a count of 0..w inclusive.
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/popcount_chunk_sequencer_if.sv
// Word-in / count-out handshake bundle of the chunked popcount sequencer.
interface popcount_chunk_sequencer_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = popcount_ctrl_pkg::cnt_w(64)
);
    logic [DATA_W-1:0] data_i;
    logic              data_val_i;
    logic              data_ready_o;
    logic [CNT_W-1:0]  data_o;
    logic              data_val_o;
    logic              busy_o;

    modport master (
        output data_i, data_val_i,
        input  data_ready_o, data_o, data_val_o, busy_o
    );

    modport slave (
        input  data_i, data_val_i,
        output data_ready_o, data_o, data_val_o, busy_o
    );
endinterface

// File: rtl/popcount_chunk_stage.sv
// Registered popcount of one CHUNK_W-bit slice, one cycle of latency.
module popcount_chunk_stage
    import popcount_ctrl_pkg::*;
#(
    parameter int CHUNK_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n_i,
    input  logic [CHUNK_W-1:0]          chunk_i,
    input  logic                        chunk_val_i,
    output logic [cnt_w(CHUNK_W)-1:0]   cnt_o,
    output logic                        cnt_val_o
);
    localparam int PCNT_W = cnt_w(CHUNK_W);

    logic [PCNT_W-1:0] sum_s;

    // Ones count of the presented slice.
    always_comb begin
        sum_s = {PCNT_W{1'b0}};
        for (int i = 0; i < CHUNK_W; i++) begin
            sum_s = sum_s + PCNT_W'(chunk_i[i]);
        end
    end

    // Output register for the partial count and its valid.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_o     <= {PCNT_W{1'b0}};
            cnt_val_o <= 1'b0;
        end else begin
            cnt_o     <= sum_s;
            cnt_val_o <= chunk_val_i;
        end
    end
endmodule

// File: rtl/popcount_chunk_sequencer.sv
// Popcount of a DATA_W word computed one CHUNK_W slice per cycle through a shared stage.
// Optional POPCNT_ZERO_SKIP_EN: an all-zero word is answered in one cycle without entering RUN.
module popcount_chunk_sequencer
    import popcount_ctrl_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int CHUNK_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n_i,
    popcount_chunk_sequencer_if.slave  bus
);
    localparam int NUM_CHUNKS = DATA_W / CHUNK_W;
    localparam int CNT_W      = cnt_w(DATA_W);
    localparam int PCNT_W     = cnt_w(CHUNK_W);
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    if ((DATA_W % CHUNK_W) != 0) begin : g_width_err
        $error("DATA_W must be an integer multiple of CHUNK_W");
    end

    popcnt_state_t      state_r;
    logic [DATA_W-1:0]  shreg_r;
    logic [IDX_W-1:0]   idx_r;
    logic [CNT_W-1:0]   acc_r;
    logic [CNT_W-1:0]   data_r;
    logic               val_r;
    logic               ready_r;
    logic               busy_r;

    logic [PCNT_W-1:0]  stage_cnt_s;
    logic               stage_val_s;
    logic [CNT_W-1:0]   acc_next_s;
    logic               skip_s;

    popcount_chunk_stage #(.CHUNK_W(CHUNK_W)) u_stage (
        .clk         (clk),
        .rst_n_i     (rst_n_i),
        .chunk_i     (shreg_r[CHUNK_W-1:0]),
        .chunk_val_i (state_r == RUN),
        .cnt_o       (stage_cnt_s),
        .cnt_val_o   (stage_val_s)
    );

    assign acc_next_s = acc_r + (stage_val_s ? CNT_W'(stage_cnt_s) : {CNT_W{1'b0}});

`ifdef POPCNT_ZERO_SKIP_EN
    assign skip_s = (bus.data_i == {DATA_W{1'b0}});
`else
    assign skip_s = 1'b0;
`endif

    // Sequencer FSM: accept, issue chunks LSB first, drain the last partial, publish.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= IDLE;
            shreg_r <= {DATA_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            acc_r   <= {CNT_W{1'b0}};
            data_r  <= {CNT_W{1'b0}};
            val_r   <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            val_r <= 1'b0;
            acc_r <= acc_next_s;
            case (state_r)
                IDLE: begin
                    if (bus.data_val_i && ready_r) begin
                        if (skip_s) begin
                            data_r <= {CNT_W{1'b0}};
                            val_r  <= 1'b1;
                        end else begin
                            shreg_r <= bus.data_i;
                            acc_r   <= {CNT_W{1'b0}};
                            idx_r   <= {IDX_W{1'b0}};
                            ready_r <= 1'b0;
                            busy_r  <= 1'b1;
                            state_r <= RUN;
                        end
                    end
                end
                RUN: begin
                    shreg_r <= shreg_r >> CHUNK_W;
                    idx_r   <= idx_r + IDX_W'(1);
                    if (idx_r == IDX_W'(NUM_CHUNKS - 1)) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    data_r  <= acc_next_s;
                    val_r   <= 1'b1;
                    acc_r   <= {CNT_W{1'b0}};
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_ready_o = ready_r;
    assign bus.data_o       = data_r;
    assign bus.data_val_o   = val_r;
    assign bus.busy_o       = busy_r;
endmodule

// File: tb/tb_popcount_chunk_sequencer.sv
// Scoreboard bench for popcount_chunk_sequencer at DATA_W=64, CHUNK_W=16.
module tb_popcount_chunk_sequencer;
    import popcount_ctrl_pkg::*;

    localparam int DATA_W = 64;
    localparam int CNT_W  = cnt_w(DATA_W);
    localparam int LAT    = 6;
`ifdef POPCNT_ZERO_SKIP_EN
    localparam int   ZLAT  = 1;
    localparam logic ZBUSY = 1'b0;
`else
    localparam int   ZLAT  = 6;
    localparam logic ZBUSY = 1'b1;
`endif

    typedef struct {
        logic [CNT_W-1:0] val;
        int               cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n_i = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    popcount_chunk_sequencer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    popcount_chunk_sequencer #(.DATA_W(DATA_W), .CHUNK_W(16)) dut (
        .clk     (clk),
        .rst_n_i (rst_n_i),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n_i && bus.data_val_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got data_o=%0d with nothing expected (cycle %0d)", bus.data_o, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_value", longint'(bus.data_o), longint'(e.val));
                chk("result_cycle", longint'(cyc), longint'(e.cyc));
            end
        end
    end

    task automatic send(input logic [DATA_W-1:0] w, input logic [CNT_W-1:0] exp, input int lat, output int hs);
        bit got;
        got = 1'b0;
        hs = -1;
        bus.data_i = w;
        bus.data_val_i = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (!got) begin
                @(negedge clk);
                if (bus.data_ready_o) begin
                    got = 1'b1;
                    hs = cyc;
                end
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got no ready expected ready within 50 cycles");
        end else begin
            sb.push_back('{exp, hs + lat});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        bus.data_val_i = 1'b0;
        bus.data_i = 64'h0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int ha, hb;
        bus.data_i = 64'h0;
        bus.data_val_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", longint'(bus.data_ready_o), 64'd1);
        chk("rst_val", longint'(bus.data_val_o), 64'd0);
        chk("rst_data", longint'(bus.data_o), 64'd0);
        chk("rst_busy", longint'(bus.busy_o), 64'd0);
        rst_n_i = 1'b1;
        @(posedge clk);
        #1;

        // 1: all ones, ready low and busy high through T+1..T+5
        send(64'hFFFF_FFFF_FFFF_FFFF, 7'd64, LAT, ha);
        go_idle();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("busy_ready", longint'(bus.data_ready_o), 64'd0);
            chk("busy_flag", longint'(bus.busy_o), 64'd1);
        end
        drain();

        // 2: chunk order and accumulation
        send(64'h8000_0000_0000_0001, 7'd2, LAT, ha);
        go_idle();
        drain();
        send(64'h0F0F_00FF_1234_0001, 7'd22, LAT, ha);
        go_idle();
        drain();

        // 3: back-to-back with valid held high
        send(64'h0000_0000_0000_00FF, 7'd8, LAT, ha);
        send(64'hAAAA_AAAA_AAAA_AAAA, 7'd32, LAT, hb);
        go_idle();
        chk("b2b_accept_cycle", longint'(hb), longint'(ha + 6));
        drain();

        // 4: backpressure, new word held while busy
        send(64'h0000_0000_0000_0003, 7'd2, LAT, ha);
        send(64'h0000_FFFF_0000_0000, 7'd16, LAT, hb);
        go_idle();
        chk("bp_accept_cycle", longint'(hb), longint'(ha + 6));
        drain();

        // 5: reset in the middle of RUN
        send(64'h1111_1111_1111_1111, 7'd16, LAT, ha);
        go_idle();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n_i = 1'b0;
        sb.delete();
        #1;
        chk("midrst_ready", longint'(bus.data_ready_o), 64'd1);
        chk("midrst_busy", longint'(bus.busy_o), 64'd0);
        chk("midrst_val", longint'(bus.data_val_o), 64'd0);
        chk("midrst_data", longint'(bus.data_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n_i = 1'b1;
        @(posedge clk);
        #1;
        send(64'h7000_0000_0000_0000, 7'd3, LAT, ha);
        go_idle();
        drain();

        // 6: zero word
        send(64'h0, 7'd0, ZLAT, ha);
        go_idle();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("zero_busy", longint'(bus.busy_o), longint'(ZBUSY));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
